seq_restoring_divider: RTL and testbench
========================================

// Module: seq_restoring_divider
// PURPOSE
//   Multi-cycle unsigned integer divider for the datapath.
//   Computes quotient = dividend / divisor and remainder = dividend % divisor.
//   Uses one restoring subtract-and-shift iteration per clock.
//   It is the inverse arithmetic counterpart to the combinational adder path:
//   each trial step is a subtraction formed as a + ~b + 1, with carry_out=1
//   meaning no borrow. A start/done handshake lets the ALU controller issue one
//   operation at a time.
// PARAMETERS
//   DATA_WID  32  operand, quotient and remainder width in bits (>=2)
// PORTS
//   clk          in   1         single clock; all state updates on rising edge
//   rst_n        in   1         reset, asynchronous assert, active-low
//   start        in   1         request; accepted only when busy==0
//   dividend     in   DATA_WID  unsigned dividend, sampled at accepted start
//   divisor      in   DATA_WID  unsigned divisor, sampled at accepted start
//   busy         out  1         high while iterating (state RUN)
//   done         out  1         one-cycle pulse: results valid from this cycle on
//   quotient     out  DATA_WID  result, held until next accepted start
//   remainder    out  DATA_WID  result, held until next accepted start
//   div_by_zero  out  1         set with done when sampled divisor==0
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous): state=IDLE. busy, done, div_by_zero,
//     quotient, remainder and the iteration counter all clear to 0.
//   Reset mid-operation aborts immediately; no done is produced.
//   FSM states: IDLE, RUN, DONE.
//   - IDLE/DONE, start=1:
//     - divisor!=0: latch operands; rem_acc=0, quo_acc=dividend, cnt=0; go RUN.
//     - divisor==0: go DONE; quotient='1 (all ones), remainder=dividend,
//       div_by_zero=1.
//   - IDLE/DONE, start=0: DONE always returns to IDLE; IDLE stays IDLE.
//   - RUN, each cycle:
//     - shifted = {rem_acc, quo_acc[DATA_WID-1]} (DATA_WID+1 bits).
//     - trial = shifted - {1'b0, divisor}.
//     - No borrow: rem_acc = trial[DATA_WID-1:0] and new quo LSB=1.
//       Borrow: rem_acc = shifted[DATA_WID-1:0] and new quo LSB=0.
//     - quo_acc = {quo_acc[DATA_WID-2:0], LSB}; cnt++.
//     - After iteration cnt==DATA_WID-1: go DONE; quotient=quo_acc,
//       remainder=rem_acc, div_by_zero=0.
//   - start during RUN is ignored (not queued). Inputs are don't-care in RUN.
//   - done=1 exactly in the DONE state. busy=1 exactly in the RUN state.
//   - start in the DONE cycle is accepted (back-to-back operations).
//   Latency: start accepted at edge 0.
//   - divisor!=0: done high in the cycle after edge DATA_WID, so the next
//     start is possible one cycle later.
//   - divisor==0: done high in the cycle after edge 0.
//   Width rule: the trial subtraction is DATA_WID+1 bits wide, so
//   shifted >= divisor never overflows. Intermediate remainder is always
//   < divisor.
//   Results and div_by_zero stay stable after DONE until the next accepted
//   start or reset.
// STRUCTURE
//   Shared package div_pkg:
//   - typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t.
//   - function cnt_w(w) = $clog2(w) for the iteration counter width.
//   Sub-module trial_subtractor #(WID):
//   - in1, in2 -> diff = in1 + ~in2 + 1, no_borrow = carry_out.
//   - Combinational; instantiated once with WID=DATA_WID+1.
//   Top level: FSM, counter, rem/quo accumulator registers, output registers.
// TESTING
//   1 reset, then start with 100/7 -> done one cycle after edge 32;
//     quotient=14, remainder=2, div_by_zero=0.
//   2 start with 5/0 -> done in the next cycle; quotient=32'hFFFF_FFFF,
//     remainder=5, div_by_zero=1; busy never asserts.
//   3 start with 32'hFFFF_FFFF/1 -> quotient=32'hFFFF_FFFF, remainder=0.
//     Then 3/10 -> quotient=0, remainder=3.
//   4 start with 1000/3, pulse start with 9/9 at cycle 10 -> second start
//     ignored; quotient=333, remainder=1. Start 9/9 in the done cycle ->
//     back-to-back result 1/0.
//   5 start with 100/7, drop rst_n at cycle 15 -> all outputs 0 at once,
//     no done. After release, 8/2 -> quotient=4, remainder=0.
//   6 random 2000 pairs (divisor!=0) vs golden model; check busy=1 for exactly
//     DATA_WID cycles and done width = 1 cycle.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Width of the iteration counter for a w-bit divide.
    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/seq_restoring_divider_trial_subtractor.sv
// Trial subtraction for one restoring step: diff = in1 + ~in2 + 1.
// no_borrow is the carry out of that sum (1 means in1 >= in2).
module trial_subtractor #(
    parameter int unsigned WID = 33
) (
    input  logic [WID-1:0] in1,
    input  logic [WID-1:0] in2,
    output logic [WID-1:0] diff,
    output logic           no_borrow
);

    // Two's-complement subtract with the carry captured as the no-borrow flag.
    always_comb begin
        {no_borrow, diff} = {1'b0, in1} + {1'b0, ~in2} + {{WID{1'b0}}, 1'b1};
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one subtract-and-shift per clock,
// with a start/done handshake. Divide by zero finishes in one cycle with
// quotient all ones, remainder = dividend and div_by_zero set.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned DATA_WID = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_WID-1:0] dividend,
    input  logic [DATA_WID-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [DATA_WID-1:0] quotient,
    output logic [DATA_WID-1:0] remainder,
    output logic                div_by_zero
);

    localparam int unsigned CW = cnt_w(DATA_WID);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WID - 1);

    div_state_t state, state_next;

    logic [DATA_WID-1:0] rem_acc;
    logic [DATA_WID-1:0] quo_acc;
    logic [DATA_WID-1:0] divisor_q;
    logic [CW-1:0]       cnt;

    logic [DATA_WID:0]   shifted;
    logic [DATA_WID:0]   trial;
    logic                no_borrow;
    logic [DATA_WID-1:0] rem_next;
    logic [DATA_WID-1:0] quo_next;
    logic                divisor_zero;
    logic                last_iter;

    // The trial result is always below the divisor when kept, so its MSB is 0.
    logic                unused_trial_msb;
    assign unused_trial_msb = trial[DATA_WID];

    assign divisor_zero = (divisor == '0);
    assign last_iter    = (cnt == LAST_CNT);

    // Shift the next dividend bit into the partial remainder.
    always_comb begin
        shifted = {rem_acc, quo_acc[DATA_WID-1]};
    end

    trial_subtractor #(
        .WID (DATA_WID + 1)
    ) u_trial (
        .in1       (shifted),
        .in2       ({1'b0, divisor_q}),
        .diff      (trial),
        .no_borrow (no_borrow)
    );

    // Restore on borrow, otherwise keep the difference; record the quotient bit.
    always_comb begin
        rem_next = no_borrow ? trial[DATA_WID-1:0] : shifted[DATA_WID-1:0];
        quo_next = {quo_acc[DATA_WID-2:0], no_borrow};
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = divisor_zero ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                state_next = last_iter ? DONE : RUN;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM outputs: pure state decode.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Accumulators, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_acc     <= '0;
            quo_acc     <= '0;
            divisor_q   <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (!divisor_zero) begin
                            divisor_q <= divisor;
                            rem_acc   <= '0;
                            quo_acc   <= dividend;
                            cnt       <= '0;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem_acc <= rem_next;
                    quo_acc <= quo_next;
                    cnt     <= cnt + CW'(1);
                    if (last_iter) begin
                        quotient    <= quo_next;
                        remainder   <= rem_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases plus random
// operands compared against plain integer division.
module tb_seq_restoring_divider;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    seq_restoring_divider #(
        .DATA_WID (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Operation a/b already presented with start=1; follow it to done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int pulse_at, input bit b2b,
                          input logic [W-1:0] na, input logic [W-1:0] nb);
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
        logic         exp_z;
        int           lat;
        int           busy_cnt;
        bit           seen;
        exp_z = (b == 0);
        exp_q = exp_z ? {W{1'b1}} : a / b;
        exp_r = exp_z ? a : a % b;
        lat   = exp_z ? 0 : W;
        busy_cnt = 0;
        seen = 0;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        for (int n = 0; n < W + 8; n++) begin
            @(negedge clk);
            if (n == pulse_at) begin
                start = 1'b1; dividend = 9; divisor = 9;
            end else if (pulse_at >= 0 && n == pulse_at + 1) begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1;
                check("done_cycle", n, lat);
                check("busy_cycles", busy_cnt, lat);
                check("quotient", quotient, exp_q);
                check("remainder", remainder, exp_r);
                check("div_by_zero", div_by_zero, exp_z);
                if (b2b) begin
                    start = 1'b1; dividend = na; divisor = nb;
                end
                break;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        if (!seen || b2b) return;
        @(negedge clk);
        check("done_width", done, 0);
        check("hold_quotient", quotient, exp_q);
        check("hold_remainder", remainder, exp_r);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; dividend = a; divisor = b;
        run_op(a, b, -1, 0, 0, 0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic divide, divide by zero, extremes.
        op(100, 7);
        op(5, 0);
        op(32'hFFFF_FFFF, 1);
        op(3, 10);

        // Start during RUN ignored, then back-to-back start in the done cycle.
        start = 1'b1; dividend = 1000; divisor = 3;
        run_op(1000, 3, 10, 1, 9, 9);
        run_op(9, 9, -1, 0, 0, 0);

        // Reset in the middle of an operation.
        start = 1'b1; dividend = 100; divisor = 7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        op(8, 2);

        // Random operands, divisor never zero.
        for (int i = 0; i < 2000; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) ra = ra >> $urandom_range(0, 31);
            if (rb == 0) rb = 1;
            op(ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
